btf_vec_pipe: RTL



---
 rtl/btf_vec_pipe.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/btf_vec_pipe.sv
// Payload delay line: N register stages with a valid bit per stage; N=0 is a plain wire.
// Latency: N cycles.
// Backpressure: every stage holds while i_en=0, and reset clears only the valid bits.
module btf_vec_dly #(
  parameter int W = 1,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_vld,
  input  logic [W-1:0] i_dat,
  output logic         o_vld,
  output logic [W-1:0] o_dat
);
  if (N == 0) begin : g_pass
    assign o_vld = i_vld;
    assign o_dat = i_dat;
  end else begin : g_regs
    logic [N-1:0]        r_vld;
    logic [N-1:0][W-1:0] r_dat;

    // Valid chain: cleared on reset, so in-flight beats are dropped; shifts only when the pipe advances.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld <= '0;
      end else if (i_en) begin
        r_vld[0] <= i_vld;
        for (int k = 1; k < N; k++) r_vld[k] <= r_vld[k-1];
      end
    end

    // Payload chain: no reset, because every consumer qualifies the payload with its valid bit.
    always_ff @(posedge clk) begin
      if (i_en) begin
        r_dat[0] <= i_dat;
        for (int k = 1; k < N; k++) r_dat[k] <= r_dat[k-1];
      end
    end

    assign o_vld = r_vld[N-1];
    assign o_dat = r_dat[N-1];
  end
endmodule

// LANES-wide unified DIT/DIF butterfly with mult, add/sub and dual-mult opcodes, all mod q.
// Latency: LAT = MODADD_LAT + INTMUL_LAT + MODRED_LAT + 1 cycles for every opcode, so beats stay in order.
// Backpressure: en = out_ready | ~out_valid freezes all stages, and in_ready = en.
module btf_vec_pipe #(
  parameter int LOGQ       = 13,
  parameter int WORD_SIZE  = 8,
  parameter int LANES      = 4,
  parameter int TAG_W      = 8,
  parameter int MODADD_LAT = 1,
  parameter int INTMUL_LAT = 1,
  parameter int MODRED_LAT = 2,
  parameter int MONT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LOGQ-1:0]       q,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_opcode,
  input  logic                  in_dit,
  input  logic                  in_div2,
  input  logic [TAG_W-1:0]      in_tag,
  input  logic [LANES*LOGQ-1:0] in_a,
  input  logic [LANES*LOGQ-1:0] in_b,
  input  logic [LANES*LOGQ-1:0] in_w,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*LOGQ-1:0] out_e,
  output logic [LANES*LOGQ-1:0] out_o,
  output logic [TAG_W-1:0]      out_tag,
  output logic [$clog2(MODADD_LAT+INTMUL_LAT+MODRED_LAT+3)-1:0] inflight,
  output logic                  idle
);
  localparam int LAT   = MODADD_LAT + INTMUL_LAT + MODRED_LAT + 1;
  localparam int CW    = $clog2(LAT + 2);
  localparam int PW    = 2 * LOGQ;
  localparam int TW    = 2 * LOGQ + 2;
  localparam int NWORD = (LOGQ + WORD_SIZE - 1) / WORD_SIZE;

  typedef logic [LOGQ-1:0]             word_t;
  typedef logic [LANES-1:0][LOGQ-1:0]  lane_t;
  typedef logic [LANES-1:0][PW-1:0]    prod_t;

  typedef struct packed {
    logic [1:0]       op;
    logic             dit;
    logic             div2;
    logic [TAG_W-1:0] tag;
  } ctl_t;

  // After the add stage: pre-add results, multiplier operands and the values the final stage needs.
  typedef struct packed { ctl_t ctl; lane_t a; lane_t s; lane_t d; lane_t m1; lane_t w; } s1_t;
  // After the multiply stage: raw double-width products.
  typedef struct packed { ctl_t ctl; lane_t a; lane_t s; lane_t d; prod_t p0; prod_t p1; } s2_t;
  // After the reduction stage: reduced products.
  typedef struct packed { ctl_t ctl; lane_t a; lane_t s; lane_t d; lane_t r0; lane_t r1; } s3_t;
  // Output register contents.
  typedef struct packed { logic [TAG_W-1:0] tag; lane_t e; lane_t o; } fin_t;

  function automatic word_t f_add(input word_t x, input word_t y, input word_t m);
    logic [LOGQ:0] t;
    t = {1'b0, x} + {1'b0, y};
    if (t >= {1'b0, m}) t = t - {1'b0, m};
    return t[LOGQ-1:0];
  endfunction

  function automatic word_t f_sub(input word_t x, input word_t y, input word_t m);
    return x - y + ((x < y) ? m : '0);
  endfunction

  // Multiply by 2^-1 mod q. q is odd, so for odd x, (x+q)/2 = (x>>1) + (q>>1) + 1, with no carry-out.
  function automatic word_t f_half(input word_t x, input word_t m);
    return (x >> 1) + (x[0] ? ((m >> 1) + word_t'(1)) : '0);
  endfunction

  // Plain reduction: restoring remainder. The product is below q*2^LOGQ, so LOGQ subtract steps suffice.
  function automatic word_t f_mod(input logic [PW-1:0] p, input word_t m);
    logic [PW-1:0] r;
    r = p;
    for (int k = LOGQ - 1; k >= 0; k--) begin
      if (r >= (PW'(m) << k)) r = r - (PW'(m) << k);
    end
    return r[LOGQ-1:0];
  endfunction

  // Word-serial Montgomery reduction. q = 1 mod 2^WORD_SIZE gives -q^-1 = -1, so each word's
  // quotient digit is simply -t mod 2^WORD_SIZE. The result before the final subtract is below 2q.
  function automatic word_t f_mont(input logic [PW-1:0] p, input word_t m);
    logic [TW-1:0]        t;
    logic [WORD_SIZE-1:0] u;
    t = TW'(p);
    for (int j = 0; j < NWORD; j++) begin
      u = -t[WORD_SIZE-1:0];
      t = (t + TW'(u) * TW'(m)) >> WORD_SIZE;
    end
    if (t >= TW'(m)) t = t - TW'(m);
    return t[LOGQ-1:0];
  endfunction

  function automatic word_t f_red(input logic [PW-1:0] p, input word_t m);
    return (MONT != 0) ? f_mont(p, m) : f_mod(p, m);
  endfunction

  logic          w_en;
  logic          w_acc;
  logic          w_dlv;
  s1_t           w_s1,  w_s1q;
  s2_t           w_s2,  w_s2q;
  s3_t           w_s3,  w_s3q;
  fin_t          w_fin, w_finq;
  logic          w_s1q_vld, w_s2q_vld, w_s3q_vld, w_fin_vld;
  logic [CW-1:0] r_inflight;

  assign w_en     = out_ready | ~out_valid;
  assign in_ready = w_en;
  assign w_acc    = in_valid & w_en;
  assign w_dlv    = out_valid & out_ready;

  // Add stage: a+b and a-b for DIF/add-sub; DIF routes (a-b) into the second multiplier.
  always_comb begin
    w_s1          = '0;
    w_s1.ctl.op   = in_opcode;
    w_s1.ctl.dit  = in_dit;
    w_s1.ctl.div2 = in_div2;
    w_s1.ctl.tag  = in_tag;
    for (int i = 0; i < LANES; i++) begin
      w_s1.a[i]  = in_a[i*LOGQ +: LOGQ];
      w_s1.w[i]  = in_w[i*LOGQ +: LOGQ];
      w_s1.s[i]  = f_add(in_a[i*LOGQ +: LOGQ], in_b[i*LOGQ +: LOGQ], q);
      w_s1.d[i]  = f_sub(in_a[i*LOGQ +: LOGQ], in_b[i*LOGQ +: LOGQ], q);
      w_s1.m1[i] = (in_opcode == 2'd0 && !in_dit) ? w_s1.d[i] : in_b[i*LOGQ +: LOGQ];
    end
  end

  btf_vec_dly #(.W($bits(s1_t)), .N(MODADD_LAT)) u_dly_add (
    .clk(clk), .rst(rst), .i_en(w_en), .i_vld(in_valid), .i_dat(w_s1),
    .o_vld(w_s1q_vld), .o_dat(w_s1q));

  // Multiply stage: both multipliers always run; p0 is only consumed by the dual-mult opcode.
  always_comb begin
    w_s2     = '0;
    w_s2.ctl = w_s1q.ctl;
    w_s2.a   = w_s1q.a;
    w_s2.s   = w_s1q.s;
    w_s2.d   = w_s1q.d;
    for (int i = 0; i < LANES; i++) begin
      w_s2.p0[i] = PW'(w_s1q.a[i])  * PW'(w_s1q.w[i]);
      w_s2.p1[i] = PW'(w_s1q.m1[i]) * PW'(w_s1q.w[i]);
    end
  end

  btf_vec_dly #(.W($bits(s2_t)), .N(INTMUL_LAT)) u_dly_mul (
    .clk(clk), .rst(rst), .i_en(w_en), .i_vld(w_s1q_vld), .i_dat(w_s2),
    .o_vld(w_s2q_vld), .o_dat(w_s2q));

  // Reduction stage: bring both products back into [0,q).
  always_comb begin
    w_s3     = '0;
    w_s3.ctl = w_s2q.ctl;
    w_s3.a   = w_s2q.a;
    w_s3.s   = w_s2q.s;
    w_s3.d   = w_s2q.d;
    for (int i = 0; i < LANES; i++) begin
      w_s3.r0[i] = f_red(w_s2q.p0[i], q);
      w_s3.r1[i] = f_red(w_s2q.p1[i], q);
    end
  end

  btf_vec_dly #(.W($bits(s3_t)), .N(MODRED_LAT)) u_dly_red (
    .clk(clk), .rst(rst), .i_en(w_en), .i_vld(w_s2q_vld), .i_dat(w_s3),
    .o_vld(w_s3q_vld), .o_dat(w_s3q));

  // Final stage: per-opcode output selection, DIT post add/sub and optional halving.
  always_comb begin
    w_fin     = '0;
    w_fin.tag = w_s3q.ctl.tag;
    for (int i = 0; i < LANES; i++) begin
      case (w_s3q.ctl.op)
        2'd0: begin
          if (w_s3q.ctl.dit) begin
            w_fin.e[i] = f_add(w_s3q.a[i], w_s3q.r1[i], q);
            w_fin.o[i] = f_sub(w_s3q.a[i], w_s3q.r1[i], q);
          end else begin
            w_fin.e[i] = w_s3q.s[i];
            w_fin.o[i] = w_s3q.r1[i];
          end
          if (w_s3q.ctl.div2) begin
            w_fin.e[i] = f_half(w_fin.e[i], q);
            w_fin.o[i] = f_half(w_fin.o[i], q);
          end
        end
        2'd1: begin
          w_fin.e[i] = w_s3q.a[i];
          w_fin.o[i] = w_s3q.r1[i];
        end
        2'd2: begin
          w_fin.e[i] = w_s3q.s[i];
          w_fin.o[i] = w_s3q.d[i];
        end
        default: begin
          w_fin.e[i] = w_s3q.r0[i];
          w_fin.o[i] = w_s3q.r1[i];
        end
      endcase
    end
  end

  btf_vec_dly #(.W($bits(fin_t)), .N(1)) u_dly_out (
    .clk(clk), .rst(rst), .i_en(w_en), .i_vld(w_s3q_vld), .i_dat(w_fin),
    .o_vld(w_fin_vld), .o_dat(w_finq));

  // In-flight count: +1 on accept, -1 on delivery, unchanged when both happen in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= '0;
    end else if (w_acc && !w_dlv) begin
      r_inflight <= r_inflight + CW'(1);
    end else if (!w_acc && w_dlv) begin
      r_inflight <= r_inflight - CW'(1);
    end
  end

  assign out_valid = w_fin_vld;
  assign out_e     = out_valid ? w_finq.e   : '0;
  assign out_o     = out_valid ? w_finq.o   : '0;
  assign out_tag   = out_valid ? w_finq.tag : '0;
  assign inflight  = r_inflight;
  assign idle      = (r_inflight == '0);
endmodule
